// File: rtl/dmem_clr_ctrl.sv
// Single-port data memory with a power-on / on-demand clear sweep; 1-cycle registered reads.
// Optional even-parity word protection when DMEM_PARITY_EN is defined (par_err tied low otherwise).
module dmem_clr_ctrl #(
    parameter int                 DATA_W  = 16,
    parameter int                 ADDR_W  = 8,
    parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dataout,
    output logic              ready,
    output logic              busy,
    output logic              clr_done,
    output logic              par_err
);
    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]   dataout_q, dataout_d;
    logic                clr_done_q, clr_done_d;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdat;
    logic [DATA_W-1:0]   rd_dat;

    // The sweep owns the write port in CLEAR; reads are sampled before the write lands (read-first).
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        clr_done_d = 1'b0;
        dataout_d  = CLR_VAL;
        mem_we     = 1'b0;
        mem_waddr  = addr;
        mem_wdat   = datain;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdat  = CLR_VAL;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_ADDR) begin
                state_d    = ST_IDLE;
                clr_done_d = 1'b1;
            end
        end else begin
            dataout_d = rd_dat;
            mem_we    = we;
            if (start_clr) begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            dataout_q  <= CLR_VAL;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            dataout_q  <= dataout_d;
            clr_done_q <= clr_done_d;
        end
    end

`ifdef DMEM_PARITY_EN
    // Top bit of each word holds even parity over the data bits.
    logic [DATA_W:0]  mem_q [DEPTH];
    logic [DATA_W:0]  rd_word;
    logic             par_err_q, par_err_d;

    assign rd_word   = mem_q[addr];
    assign rd_dat    = rd_word[DATA_W-1:0];
    assign par_err_d = (state_q == ST_IDLE) && (^rd_word);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= {^mem_wdat, mem_wdat};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`else
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rd_dat = mem_q[addr];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdat;
        end
    end

    assign par_err = 1'b0;
`endif

    assign dataout  = dataout_q;
    assign busy     = (state_q == ST_CLEAR);
    assign ready    = ~busy;
    assign clr_done = clr_done_q;
endmodule
